// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin APB master sharing one bus between NREQ requesters; `define APB_TIMEOUT_EN adds an ACCESS-phase watchdog
module apb_arb_master #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 8,
  parameter int NREQ        = 2,
  parameter int NSLV        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_err,
  output logic [DWIDTH-1:0]        req_rdata,
  output logic [NSLV-1:0]          PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY
);
  localparam int SELBITS = $clog2(NSLV);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [PW-1:0] ptr, g, nxt, idx;
  logic [AWIDTH-1:0] n_addr;
  logic [DWIDTH-1:0] n_data;
  logic n_wr, to;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign to = state == ACCESS && cnt == CW'(TIMEOUT_CYC - 1);
  // count ACCESS cycles; cleared whenever the FSM is not in ACCESS
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) cnt <= '0;
    else cnt <= state == ACCESS ? cnt + 1'b1 : '0;
`else
  assign to = 1'b0;
`endif
  // first valid requester at or after the round-robin pointer
  always_comb begin
    nxt = ptr;
    idx = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) nxt = idx;
    end
  end
  // command fields of the requester about to be granted
  always_comb begin
    n_addr = '0;
    n_data = '0;
    n_wr = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (nxt == PW'(i)) begin
        n_addr = req_addr[i*AWIDTH +: AWIDTH];
        n_data = req_wdata[i*DWIDTH +: DWIDTH];
        n_wr = req_write[i];
      end
  end
  // IDLE/SETUP/ACCESS sequencer; idle arbitration is skipped while req_done is high
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      PSEL <= '0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
      req_done <= '0;
      req_err <= '0;
      req_rdata <= '0;
    end else begin
      req_done <= '0;
      req_err <= '0;
      case (state)
        IDLE: if (req_done == '0 && |req_valid) begin
          g <= nxt;
          PADDR <= n_addr;
          PWDATA <= n_data;
          PWRITE <= n_wr;
          PSEL <= NSLV'(1) << n_addr[AWIDTH-1 -: SELBITS];
          state <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (PREADY || to) begin
          PSEL <= '0;
          PENABLE <= 1'b0;
          req_done[g] <= 1'b1;
          req_err[g] <= !PREADY;
          if (PREADY && !PWRITE) req_rdata <= PRDATA;
          ptr <= int'(g) == NREQ - 1 ? '0 : g + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: vector table, corner sequences and randomized run against a transaction-level model
module tb_apb_arb_master;
  logic PCLK = 0, PRESET = 0;
  logic [1:0] req_valid = 0, req_write = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_done, req_err;
  logic [7:0] req_rdata, PADDR, PWDATA;
  logic [7:0] PRDATA = 0;
  logic PREADY = 0, PENABLE, PWRITE;
  logic [3:0] PSEL;
  int n_cmp = 0, n_err = 0;

  apb_arb_master dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done), .req_err(req_err),
    .req_rdata(req_rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int r;
    bit wr;
    logic [7:0] addr, wdata;
    int w;
    logic [7:0] prd;
    logic [3:0] psel;
    logic [7:0] rdata;
  } vec_t;
  vec_t tv[4];

  logic [7:0] smem[256], rmem[256];
  logic [7:0] ra[2], rd[2];
  logic rw[2];
  logic mptr, cur_g;
  logic [1:0] vlast;
  logic [3:0] pp;
  logic [1:0] dn[4];
  logic [7:0] pa[4];
  int nd, na, ndone, pen;
  logic [7:0] rsave;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic setreq(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d);
    req_write[r] = wr;
    req_addr[r*8 +: 8] = a;
    req_wdata[r*8 +: 8] = d;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset;
    #2 PRESET = 1;
    #1 chk("rst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_done, req_err, req_rdata}, 64'd0);
    tick;
    PRESET = 0;
  endtask

  function automatic logic rr(input logic [1:0] v, input logic p);
    if (v[p]) return p;
    if (v[!p]) return !p;
    return p;
  endfunction

  initial begin
    tv[0] = '{0, 1'b1, 8'h45, 8'hA5, 0, 8'h00, 4'b0010, 8'h00};
    tv[1] = '{1, 1'b0, 8'hC3, 8'h00, 2, 8'h5A, 4'b1000, 8'h5A};
    tv[2] = '{0, 1'b0, 8'h10, 8'h00, 1, 8'h3C, 4'b0001, 8'h3C};
    tv[3] = '{1, 1'b1, 8'h80, 8'h77, 3, 8'hEE, 4'b0100, 8'h3C};
    do_reset;
    foreach (tv[n]) begin
      setreq(tv[n].r, tv[n].wr, tv[n].addr, tv[n].wdata);
      PREADY = 0;
      tick;
      chk("tv_psel", PSEL, tv[n].psel);
      chk("tv_paddr", PADDR, tv[n].addr);
      chk("tv_pwrite", PWRITE, tv[n].wr);
      chk("tv_setup_pen", PENABLE, 0);
      if (tv[n].wr) chk("tv_pwdata", PWDATA, tv[n].wdata);
      tick;
      chk("tv_access_pen", PENABLE, 1);
      for (int j = 0; j < tv[n].w; j++) begin
        tick;
        chk("tv_wait_hold", {PENABLE, PSEL, req_done}, {1'b1, tv[n].psel, 2'b00});
      end
      PREADY = 1;
      PRDATA = tv[n].prd;
      tick;
      chk("tv_done", req_done, 2'b01 << tv[n].r);
      chk("tv_rdata", req_rdata, tv[n].rdata);
      chk("tv_idle_bus", {PSEL, PENABLE}, 0);
      req_valid = 0;
      PREADY = 0;
      tick;
      chk("tv_done_pulse", req_done, 0);
    end

    // two requesters contending continuously
    do_reset;
    setreq(0, 1, 8'h12, 8'h01);
    setreq(1, 1, 8'h92, 8'h02);
    PREADY = 1;
    pp = 0; nd = 0; na = 0;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      tick;
      if (PSEL != 0 && pp == 0 && na < 4) begin pa[na] = PADDR; na++; end
      if (req_done != 0 && nd < 4) begin dn[nd] = req_done; nd++; end
      pp = PSEL;
      req_valid = ~req_done;
    end
    chk("arb_count", nd, 4);
    for (int k = 0; k < nd; k++) begin
      chk("arb_order", dn[k], k % 2 ? 2'b10 : 2'b01);
      chk("arb_paddr", pa[k], k % 2 ? 8'h92 : 8'h12);
    end
    req_valid = 0;
    PREADY = 0;
    tick;
    tick;

    // reset while a transfer sits in ACCESS
    do_reset;
    setreq(1, 0, 8'hC3, 8'h00);
    tick;
    tick;
    chk("rstmid_access", PENABLE, 1);
    setreq(0, 1, 8'h45, 8'h99);
    #2 PRESET = 1;
    #1 chk("rstmid_async", {PSEL, PENABLE}, 0);
    chk("rstmid_nodone", req_done, 0);
    tick;
    chk("rstmid_nodone_edge", req_done, 0);
    PRESET = 0;
    tick;
    chk("rstmid_regrant", PADDR, 8'h45);
    PREADY = 1;
    tick;
    tick;
    chk("rstmid_done", req_done, 2'b01);
    req_valid = 0;
    PREADY = 0;
    tick;
    tick;

    // command changes after grant are ignored
    setreq(0, 1, 8'h45, 8'h11);
    tick;
    req_addr[7:0] = 8'hFF;
    req_wdata[7:0] = 8'hEE;
    chk("ign_setup", {PADDR, PWDATA}, {8'h45, 8'h11});
    tick;
    req_valid[0] = 0;
    chk("ign_access", {PADDR, PWDATA}, {8'h45, 8'h11});
    PREADY = 1;
    tick;
    chk("ign_done", req_done, 2'b01);
    PREADY = 0;
    tick;

`ifdef APB_TIMEOUT_EN
    rsave = req_rdata;
    setreq(0, 0, 8'h20, 8'h00);
    PREADY = 0;
    pen = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (PENABLE) pen++;
      if (req_done != 0) break;
    end
    chk("to_pen_cycles", pen, 16);
    chk("to_done_err", {req_done, req_err}, {2'b01, 2'b01});
    chk("to_rdata", req_rdata, rsave);
    req_valid = 0;
    tick;
    chk("to_idle", {PSEL, PENABLE, req_done}, 0);
`endif

    // randomized traffic against a memory-level model
    do_reset;
    for (int i = 0; i < 256; i++) begin
      smem[i] = 8'($urandom);
      rmem[i] = smem[i];
    end
    mptr = 0; cur_g = 0; pp = 0; vlast = 0; ndone = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (PSEL != 0 && pp == 0) begin
        cur_g = rr(vlast, mptr);
        chk("rnd_paddr", PADDR, ra[cur_g]);
        chk("rnd_pwrite", PWRITE, rw[cur_g]);
        chk("rnd_psel", PSEL, 4'b0001 << ra[cur_g][7:6]);
        if (rw[cur_g]) chk("rnd_pwdata", PWDATA, rd[cur_g]);
      end
      if (req_done != 0) begin
        chk("rnd_done", req_done, 2'b01 << cur_g);
        chk("rnd_err", req_err, 0);
        if (rw[cur_g]) rmem[ra[cur_g]] = rd[cur_g];
        else chk("rnd_rdata", req_rdata, rmem[ra[cur_g]]);
        if (PWRITE) smem[PADDR] = PWDATA;
        mptr = !cur_g;
        ndone++;
      end
      chk("rnd_onehot", $onehot0(PSEL), 1);
      chk("rnd_pen_psel", PENABLE && PSEL == 0, 0);
      pp = PSEL;
      for (int i = 0; i < 2; i++)
        if (req_done[i]) req_valid[i] = 0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          ra[i] = 8'($urandom);
          rd[i] = 8'($urandom);
          rw[i] = 1'($urandom);
          setreq(i, rw[i], ra[i], rd[i]);
        end
      vlast = req_valid;
      PREADY = $urandom_range(0, 2) != 0;
      PRDATA = smem[PADDR];
    end
    chk("rnd_progress", ndone >= 100, 1);
    req_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
